huffman_stream_decoder: RTL

//  Parametrised, flow-controlled successor to the stage-1 Huffman decode path of the sparse pattern decoder.
//  - Input: packed 64-bit code-stream words from memory responses.
//  - Output: one decoded symbol per cycle, using a loadable code-length/symbol LUT.
//  - Adds valid/ready on both sides, a last-word bit count, drain/done signalling and invalid-code detection.
//  - Sits between the response demux and the argument-extraction stage.

---
 rtl/spm_decode_pkg.sv | 17 +
 rtl/huffman_lut.sv | 23 ++
 rtl/huffman_stream_decoder.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/spm_decode_pkg.sv
// Shared decode-path definitions: LUT entry layout, FSM states and field widths.
// Also used by the argument-extraction stage.
package spm_decode_pkg;

    localparam int unsigned HSD_LEN_WIDTH = 4;
    localparam int unsigned HSD_SYM_WIDTH = 7;
    localparam int unsigned HSD_LEN_LSB   = 0;
    localparam int unsigned HSD_SYM_LSB   = HSD_LEN_WIDTH;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_ERR   = 2'd3
    } hsd_state_e;

endpackage

// File: rtl/huffman_lut.sv
// Code-length/symbol lookup table.
// Single synchronous write port and asynchronous read port; contents are not reset.
module huffman_lut #(
    parameter int unsigned ADDR_WIDTH = 9,
    parameter int unsigned DATA_WIDTH = 11
) (
    input  logic                  clk,
    input  logic                  i_we,
    input  logic [ADDR_WIDTH-1:0] i_waddr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic [ADDR_WIDTH-1:0] i_raddr,
    output logic [DATA_WIDTH-1:0] o_rdata
);

    logic [DATA_WIDTH-1:0] r_mem [2**ADDR_WIDTH];

    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/huffman_stream_decoder.sv
// Flow-controlled Huffman stream decoder: packed words in, one LUT-decoded symbol per cycle out.
// Optional HSD_STATS_EN adds sym_count/bit_count statistics outputs.
module huffman_stream_decoder
    import spm_decode_pkg::*;
#(
    parameter int unsigned IN_WIDTH       = 64,
    parameter int unsigned LUT_ADDR_WIDTH = 9,
    parameter int unsigned LEN_WIDTH      = HSD_LEN_WIDTH,
    parameter int unsigned SYM_WIDTH      = HSD_SYM_WIDTH
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            lut_we,
    input  logic [LUT_ADDR_WIDTH-1:0]       lut_addr,
    input  logic [SYM_WIDTH+LEN_WIDTH-1:0]  lut_wdata,
    input  logic                            start,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [IN_WIDTH-1:0]             in_data,
    input  logic                            in_last,
    input  logic [$clog2(IN_WIDTH):0]       in_bits,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [SYM_WIDTH-1:0]            out_sym,
    output logic                            done,
    output logic                            err
`ifdef HSD_STATS_EN
    ,
    output logic [31:0]                     sym_count,
    output logic [31:0]                     bit_count
`endif
);

    localparam int unsigned BUF_WIDTH = IN_WIDTH + LUT_ADDR_WIDTH - 1;
    localparam int unsigned FILL_W    = $clog2(BUF_WIDTH + 1);
    localparam int unsigned BITS_W    = $clog2(IN_WIDTH) + 1;
    localparam int unsigned ENT_W     = SYM_WIDTH + LEN_WIDTH;
    localparam logic [FILL_W-1:0] WIN_FILL  = FILL_W'(LUT_ADDR_WIDTH);
    localparam logic [FILL_W-1:0] WORD_FILL = FILL_W'(IN_WIDTH);

    hsd_state_e                r_state, w_next_state;
    logic [BUF_WIDTH-1:0]      r_buf;
    logic [FILL_W-1:0]         r_fill;
    logic                      r_last_seen;
    logic                      r_out_valid;
    logic [SYM_WIDTH-1:0]      r_out_sym;
    logic                      r_done;
    logic                      r_err;

    logic [LUT_ADDR_WIDTH-1:0] w_idx;
    logic [ENT_W-1:0]          w_entry;
    logic [LEN_WIDTH-1:0]      w_len;
    logic [FILL_W-1:0]         w_len_f;
    logic [SYM_WIDTH-1:0]      w_sym;
    logic                      w_len_bad, w_full, w_slot_free, w_lut_we;
    logic                      w_in_ready, w_load, w_fire, w_bad, w_done, w_start;
    logic [IN_WIDTH-1:0]       w_word;
    logic [FILL_W-1:0]         w_add;

    assign w_lut_we = lut_we && (r_state == ST_IDLE);

    huffman_lut #(
        .ADDR_WIDTH (LUT_ADDR_WIDTH),
        .DATA_WIDTH (ENT_W)
    ) u_lut (
        .clk     (clk),
        .i_we    (w_lut_we),
        .i_waddr (lut_addr),
        .i_wdata (lut_wdata),
        .i_raddr (w_idx),
        .o_rdata (w_entry)
    );

    // Window bits at or above fill are forced to zero before the LUT lookup.
    always_comb begin
        w_idx = '0;
        for (int unsigned i = 0; i < LUT_ADDR_WIDTH; i++)
            w_idx[i] = r_buf[i] && (r_fill > FILL_W'(i));
    end

    always_comb begin
        w_word = '0;
        for (int unsigned i = 0; i < IN_WIDTH; i++)
            w_word[i] = in_data[i] && (!in_last || (in_bits > BITS_W'(i)));
    end

    assign w_len       = w_entry[HSD_LEN_LSB +: LEN_WIDTH];
    assign w_sym       = w_entry[LEN_WIDTH +: SYM_WIDTH];
    assign w_len_f     = FILL_W'(w_len);
    assign w_len_bad   = (w_len == '0) || (w_len_f > WIN_FILL);
    assign w_full      = (r_fill >= WIN_FILL);
    assign w_slot_free = !r_out_valid || out_ready;
    assign w_add       = in_last ? FILL_W'(in_bits) : WORD_FILL;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= ST_IDLE;
        else      r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:  if (start) w_next_state = ST_RUN;
            ST_RUN:   if (w_bad) w_next_state = ST_ERR;
                      else if (w_load && in_last) w_next_state = ST_DRAIN;
            ST_DRAIN: if (w_bad) w_next_state = ST_ERR;
                      else if (w_done) w_next_state = ST_IDLE;
            ST_ERR:   if (start) w_next_state = ST_RUN;
            default:  w_next_state = ST_IDLE;
        endcase
    end

    // A tail shorter than the window whose entry overruns it ends the stream, not an error.
    always_comb begin
        w_in_ready = (r_state == ST_RUN) && !w_full && !r_last_seen;
        w_load     = w_in_ready && in_valid;
        w_start    = start && ((r_state == ST_IDLE) || (r_state == ST_ERR));
        w_fire     = 1'b0;
        w_bad      = 1'b0;
        w_done     = 1'b0;
        case (r_state)
            ST_RUN: begin
                if (w_full && w_slot_free) begin
                    if (w_len_bad) w_bad  = 1'b1;
                    else           w_fire = 1'b1;
                end
            end
            ST_DRAIN: begin
                if (r_fill == '0) w_done = 1'b1;
                else if (!w_full && (w_len_f > r_fill)) w_done = 1'b1;
                else if (w_slot_free) begin
                    if (w_len_bad) w_bad  = 1'b1;
                    else           w_fire = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_buf       <= '0;
            r_fill      <= '0;
            r_last_seen <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_sym   <= '0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_done <= w_done;
            if (w_bad) r_err <= 1'b1;
            if (w_start) begin
                r_buf       <= '0;
                r_fill      <= '0;
                r_last_seen <= 1'b0;
                r_err       <= 1'b0;
            end else if (w_load) begin
                r_buf  <= r_buf | (BUF_WIDTH'(w_word) << r_fill);
                r_fill <= r_fill + w_add;
                if (in_last) r_last_seen <= 1'b1;
            end else if (w_fire) begin
                r_buf  <= r_buf >> w_len;
                r_fill <= r_fill - w_len_f;
            end
            if (w_fire) begin
                r_out_valid <= 1'b1;
                r_out_sym   <= w_sym;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = r_out_valid;
    assign out_sym   = r_out_sym;
    assign done      = r_done;
    assign err       = r_err;

`ifdef HSD_STATS_EN
    logic [31:0] r_sym_count, r_bit_count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sym_count <= '0;
            r_bit_count <= '0;
        end else if (w_start) begin
            r_sym_count <= '0;
            r_bit_count <= '0;
        end else if (w_fire) begin
            r_sym_count <= r_sym_count + 32'd1;
            r_bit_count <= r_bit_count + 32'(w_len);
        end
    end

    assign sym_count = r_sym_count;
    assign bit_count = r_bit_count;
`endif

endmodule
